// File: rtl/cam_pkg.sv
// Shared definitions for the CMOS camera capture path: pixel format,
// capture FSM encoding and default frame geometry.
package cam_pkg;

  // Default frame geometry of the attached sensor.
  localparam int CAM_H_PIX   = 512;
  localparam int CAM_V_LINES = 8;

  // Camera byte and assembled pixel widths.
  localparam int BYTE_W = 8;
  localparam int PIX_W  = 16;

  // RGB565 field positions inside an assembled pixel.
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // Capture FSM encoding.
  typedef logic [1:0] cam_state_t;
  localparam cam_state_t ST_WAIT_VS = 2'd0;
  localparam cam_state_t ST_SYNC    = 2'd1;
  localparam cam_state_t ST_SKIP    = 2'd2;
  localparam cam_state_t ST_ACTIVE  = 2'd3;

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs consecutive camera bytes into one 16-bit pixel. The first byte of
// a pair is parked in hi_q; the second completes the pixel, which is
// presented one edge later together with a single-cycle strobe.
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_en_i,
  input  logic              clr_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              emit_o,
  output logic              phase_lo_o,
  output logic              pix_valid_o,
  output logic [PIX_W-1:0]  pix_data_o
);

  logic              phase_lo_q, phase_lo_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              emit_s;

  // A pixel completes when a byte arrives while the high half is parked.
  assign emit_s = byte_en_i & phase_lo_q;

  // Next-state logic for the byte phase, high-byte holding register and pixel output.
  always_comb begin
    phase_lo_d  = phase_lo_q;
    hi_d        = hi_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    if (clr_i) begin
      // Line end or frame abort: any dangling high byte is dropped.
      phase_lo_d = 1'b0;
    end else if (byte_en_i) begin
      if (phase_lo_q) begin
        pix_data_d  = {hi_q, data_i};
        pix_valid_d = 1'b1;
        phase_lo_d  = 1'b0;
      end else begin
        hi_d       = data_i;
        phase_lo_d = 1'b1;
      end
    end else begin
      phase_lo_d = phase_lo_q;
    end
  end

  // Pixel assembly registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_lo_q  <= 1'b0;
      hi_q        <= {BYTE_W{1'b0}};
      pix_data_q  <= {PIX_W{1'b0}};
      pix_valid_q <= 1'b0;
    end else begin
      phase_lo_q  <= phase_lo_d;
      hi_q        <= hi_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign emit_o      = emit_s;
  assign phase_lo_o  = phase_lo_q;
  assign pix_valid_o = pix_valid_q;
  assign pix_data_o  = pix_data_q;

endmodule

// File: rtl/cmos_capture.sv
// Receiver for an 8-bit parallel CMOS camera port. Registers the pins,
// tracks frame sync, drops start-up frames, assembles RGB565 pixels with
// x/y coordinates and flags malformed lines or frames. Everything runs on
// the camera pixel clock.
module cmos_capture
  import cam_pkg::*;
#(
  parameter int H_PIX       = CAM_H_PIX,
  parameter int V_LINES     = CAM_V_LINES,
  parameter int SKIP_FRAMES = 0,
  parameter int XY_W        = 16
) (
  input  logic              cmos_pclk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] cmos_data,
  input  logic              cmos_href,
  input  logic              cmos_vsyn,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic [XY_W-1:0]   pix_x,
  output logic [XY_W-1:0]   pix_y,
  output logic              frame_start,
  output logic              frame_done,
  output logic              line_err
);

  localparam logic [XY_W-1:0] H_CNT    = XY_W'(H_PIX);
  localparam logic [XY_W-1:0] Y_LAST   = XY_W'(V_LINES - 1);
  localparam logic [XY_W-1:0] XY_ZERO  = {XY_W{1'b0}};
  localparam logic [XY_W-1:0] XY_MAX   = {XY_W{1'b1}};
  localparam logic [XY_W-1:0] XY_ONE   = {{(XY_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]      SKIP_CFG = 5'(SKIP_FRAMES);

  // Pin registers and edge-detect history.
  logic              vsyn_q, vsyn_prev_q, href_q, href_prev_q;
  logic [BYTE_W-1:0] data_q;

  // Control and counter state.
  cam_state_t        state_q, state_d;
  logic [3:0]        skip_cnt_q, skip_cnt_d;
  logic [XY_W-1:0]   pix_x_q, pix_x_d;
  logic [XY_W-1:0]   pix_y_q, pix_y_d;
  logic              frame_full_q, frame_full_d;
  logic              in_frame_q, in_frame_d;
  logic              started_q, started_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;

  // Decoded events.
  logic              href_eff_s, vs_fall_s, href_fall_s, active_s;
  logic              byte_en_s, enter_active_s, done_now_s, abort_s;
  logic              skip_more_s, pack_clr_s, err_s;
  logic              emit_s, phase_lo_s, pack_valid_s;
  logic [PIX_W-1:0]  pack_data_s;
  logic [XY_W-1:0]   x_inc_s, x_cnt_s;

  // Bytes presented during vertical blanking never count as line data.
  assign href_eff_s  = href_q & ~vsyn_q;
  assign vs_fall_s   = vsyn_prev_q & ~vsyn_q;
  assign href_fall_s = href_prev_q & ~href_eff_s;
  assign active_s    = (state_q == ST_ACTIVE);

  // Once the frame holds V_LINES lines, further bytes are not packed.
  assign byte_en_s   = active_s & href_eff_s & ~frame_full_q;

  assign skip_more_s    = ({1'b0, skip_cnt_q} + 5'd1) <= SKIP_CFG;
  assign enter_active_s = (state_q == ST_SYNC) & vs_fall_s & ~skip_more_s;

  // Line end that completes the last expected line of the frame.
  assign done_now_s = active_s & href_fall_s & ~frame_full_q & (pix_y_q == Y_LAST);

  // Vertical sync arriving while a frame is only partly received.
  assign abort_s = active_s & vsyn_q & in_frame_q & ~frame_full_q & ~done_now_s;

  assign pack_clr_s = href_fall_s | abort_s | enter_active_s;

  // Column count including a pixel strobed in this cycle, saturating.
  assign x_inc_s = (pix_x_q == XY_MAX) ? pix_x_q : (pix_x_q + XY_ONE);
  assign x_cnt_s = pack_valid_s ? x_inc_s : pix_x_q;

  cam_byte_pack u_pack (
    .clk_i       (cmos_pclk),
    .rst_i       (rst),
    .byte_en_i   (byte_en_s),
    .clr_i       (pack_clr_s),
    .data_i      (data_q),
    .emit_o      (emit_s),
    .phase_lo_o  (phase_lo_s),
    .pix_valid_o (pack_valid_s),
    .pix_data_o  (pack_data_s)
  );

  // Register the camera pins once, and vsyn/href a second time for edge detection.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      vsyn_q      <= 1'b0;
      vsyn_prev_q <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= {BYTE_W{1'b0}};
    end else begin
      vsyn_q      <= cmos_vsyn;
      vsyn_prev_q <= vsyn_q;
      href_q      <= cmos_href;
      href_prev_q <= href_eff_s;
      data_q      <= cmos_data;
    end
  end

  // Frame-sync FSM: find blanking, count off skipped frames, then capture.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    case (state_q)
      ST_WAIT_VS: begin
        if (vsyn_q) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_WAIT_VS;
        end
      end
      ST_SYNC: begin
        if (vs_fall_s) begin
          if (skip_more_s) begin
            skip_cnt_d = skip_cnt_q + 4'd1;
            state_d    = ST_SKIP;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_SKIP: begin
        if (vsyn_q) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_ACTIVE: begin
        if (vsyn_q) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_WAIT_VS;
      end
    endcase
  end

  // Coordinate counters: x counts emitted pixels in the line, y counts lines.
  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (enter_active_s || abort_s) begin
      pix_x_d = XY_ZERO;
      pix_y_d = XY_ZERO;
    end else if (active_s && href_fall_s) begin
      pix_x_d = XY_ZERO;
      if (!frame_full_q && (pix_y_q < Y_LAST)) begin
        pix_y_d = pix_y_q + XY_ONE;
      end else begin
        pix_y_d = pix_y_q;
      end
    end else begin
      pix_x_d = x_cnt_s;
    end
  end

  // Frame bookkeeping, start/done strobes and sticky error detection.
  always_comb begin
    frame_full_d  = frame_full_q;
    in_frame_d    = in_frame_q;
    started_d     = started_q;
    frame_start_d = emit_s & ~started_q;
    frame_done_d  = done_now_s | abort_s;
    err_s         = 1'b0;

    if (enter_active_s || abort_s) begin
      frame_full_d = 1'b0;
      in_frame_d   = 1'b0;
      started_d    = 1'b0;
    end else if (done_now_s) begin
      frame_full_d = 1'b1;
      in_frame_d   = 1'b0;
    end else begin
      if (byte_en_s) begin
        in_frame_d = 1'b1;
      end else begin
        in_frame_d = in_frame_q;
      end
      if (emit_s) begin
        started_d = 1'b1;
      end else begin
        started_d = started_q;
      end
    end

    // Short, long or odd-byte line inside the expected frame.
    if (active_s && href_fall_s && !frame_full_q && (phase_lo_s || (x_cnt_s != H_CNT))) begin
      err_s = 1'b1;
    end else if (active_s && href_eff_s && frame_full_q) begin
      // Line data beyond the expected number of lines.
      err_s = 1'b1;
    end else if (abort_s) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end

    line_err_d = line_err_q | err_s;
  end

  // Control, counter and flag registers.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      state_q       <= ST_WAIT_VS;
      skip_cnt_q    <= 4'd0;
      pix_x_q       <= XY_ZERO;
      pix_y_q       <= XY_ZERO;
      frame_full_q  <= 1'b0;
      in_frame_q    <= 1'b0;
      started_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_full_q  <= frame_full_d;
      in_frame_q    <= in_frame_d;
      started_q     <= started_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pix_data    = pack_data_s;
  assign pix_valid   = pack_valid_s;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture. Instance a captures every frame,
// instance b discards two start-up frames; both see the same pins.
module tb_cmos_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmos_data = 8'h00;
  logic        cmos_href = 1'b0;
  logic        cmos_vsyn = 1'b0;

  logic [15:0] a_pix_data, b_pix_data;
  logic        a_pix_valid, b_pix_valid;
  logic [15:0] a_pix_x, a_pix_y, b_pix_x, b_pix_y;
  logic        a_frame_start, a_frame_done, a_line_err;
  logic        b_frame_start, b_frame_done, b_line_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor statistics.
  int          n_pv, n_fs, n_fd, n_bad, fs_bad, n_pv2, n_fs2, n_fd2;
  logic [15:0] exp_val, last_data, last_x, last_y;
  int          exp_x, exp_y;

  cmos_capture #(.H_PIX(512), .V_LINES(8), .SKIP_FRAMES(0), .XY_W(16)) dut_a (
    .cmos_pclk(clk), .rst(rst), .cmos_data(cmos_data), .cmos_href(cmos_href),
    .cmos_vsyn(cmos_vsyn), .pix_data(a_pix_data), .pix_valid(a_pix_valid),
    .pix_x(a_pix_x), .pix_y(a_pix_y), .frame_start(a_frame_start),
    .frame_done(a_frame_done), .line_err(a_line_err)
  );

  cmos_capture #(.H_PIX(512), .V_LINES(8), .SKIP_FRAMES(2), .XY_W(16)) dut_b (
    .cmos_pclk(clk), .rst(rst), .cmos_data(cmos_data), .cmos_href(cmos_href),
    .cmos_vsyn(cmos_vsyn), .pix_data(b_pix_data), .pix_valid(b_pix_valid),
    .pix_x(b_pix_x), .pix_y(b_pix_y), .frame_start(b_frame_start),
    .frame_done(b_frame_done), .line_err(b_line_err)
  );

  always #5 clk = ~clk;

  // Collect strobes and compare each pixel with the incrementing test pattern.
  always @(negedge clk) begin
    if (a_pix_valid === 1'b1) begin
      n_pv++;
      last_data = a_pix_data;
      last_x    = a_pix_x;
      last_y    = a_pix_y;
      if (a_pix_data !== exp_val || a_pix_x !== exp_x[15:0] || a_pix_y !== exp_y[15:0]) n_bad++;
      exp_val = exp_val + 16'd1;
      exp_x++;
      if (exp_x == 512) begin
        exp_x = 0;
        exp_y++;
      end
    end
    if (a_frame_start === 1'b1) begin
      n_fs++;
      if (!(a_pix_valid === 1'b1 && a_pix_x === 16'd0 && a_pix_y === 16'd0)) fs_bad++;
    end
    if (a_frame_done === 1'b1) n_fd++;
    if (b_pix_valid === 1'b1) n_pv2++;
    if (b_frame_start === 1'b1) n_fs2++;
    if (b_frame_done === 1'b1) n_fd2++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon(input logic [15:0] base);
    n_pv = 0; n_fs = 0; n_fd = 0; n_bad = 0; fs_bad = 0;
    n_pv2 = 0; n_fs2 = 0; n_fd2 = 0;
    exp_val = base; exp_x = 0; exp_y = 0;
    last_data = 16'h0000; last_x = 16'h0000; last_y = 16'h0000;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else n_pass++;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmos_href = 1'b0; cmos_vsyn = 1'b0; cmos_data = 8'h00;
    tick;
    rst = 1'b0;
  endtask

  task automatic vs_pulse;
    cmos_vsyn = 1'b1;
    repeat (4) tick;
    cmos_vsyn = 1'b0;
    repeat (4) tick;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmos_data = b; cmos_href = 1'b1;
    tick;
  endtask

  task automatic end_line;
    cmos_href = 1'b0; cmos_data = 8'h00;
    repeat (6) tick;
  endtask

  task automatic send_line(input int npix, input logic [15:0] base);
    logic [15:0] v;
    for (int i = 0; i < npix; i++) begin
      v = base + 16'(i);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
    end
    end_line();
  endtask

  task automatic send_frame(input int nlines, input logic [15:0] base);
    vs_pulse();
    for (int l = 0; l < nlines; l++) send_line(512, base + 16'(l * 512));
    repeat (4) tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    n_checks++;
    if ({a_pix_data, a_pix_valid, a_pix_x, a_pix_y, a_frame_start, a_frame_done, a_line_err} !== 52'd0) begin
      $display("FAIL reset_outputs: got data=%h v=%b x=%0d y=%0d fs=%b fd=%b err=%b, expected all 0",
               a_pix_data, a_pix_valid, a_pix_x, a_pix_y, a_frame_start, a_frame_done, a_line_err);
    end else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_latency;
    do_reset();
    vs_pulse();
    clear_mon(16'h0000);
    send_byte(8'hAB);
    send_byte(8'hCD);
    cmos_href = 1'b0;
    n_checks++;
    if (a_pix_valid !== 1'b0) $display("FAIL lat_early: pix_valid=%b, expected 0", a_pix_valid);
    else n_pass++;
    tick;
    n_checks++;
    if (a_pix_valid !== 1'b1 || a_pix_data !== 16'hABCD)
      $display("FAIL lat_pixel: valid=%b data=%h, expected 1 ABCD", a_pix_valid, a_pix_data);
    else n_pass++;
    n_checks++;
    if (a_frame_start !== 1'b1 || a_pix_x !== 16'd0 || a_pix_y !== 16'd0)
      $display("FAIL lat_start: fs=%b x=%0d y=%0d, expected 1 0 0", a_frame_start, a_pix_x, a_pix_y);
    else n_pass++;
    tick;
    n_checks++;
    if (a_pix_valid !== 1'b0 || a_frame_start !== 1'b0)
      $display("FAIL lat_width: valid=%b fs=%b, expected 0 0", a_pix_valid, a_frame_start);
    else n_pass++;
    repeat (4) tick;
  endtask

  task automatic test_odd_line;
    do_reset();
    vs_pulse();
    clear_mon(16'h0000);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    end_line();
    check("odd_count", n_pv, 1);
    check("odd_data", last_data, 16'h1122);
    check("odd_err", a_line_err, 1);
    send_byte(8'h44);
    send_byte(8'h55);
    end_line();
    check("odd_next_count", n_pv, 2);
    check("odd_next_data", last_data, 16'h4455);
    check("odd_next_x", last_x, 0);
    check("odd_next_y", last_y, 1);
  endtask

  task automatic test_full_frame;
    do_reset();
    clear_mon(16'h8000);
    send_frame(8, 16'h8000);
    repeat (6) tick;
    check("full_pixels", n_pv, 4096);
    check("full_data", n_bad, 0);
    check("full_last", last_data, 16'h8FFF);
    check("full_last_xy", {last_x, last_y}, {16'd511, 16'd7});
    check("full_fstart", n_fs, 1);
    check("full_fstart_pos", fs_bad, 0);
    check("full_fdone", n_fd, 1);
    check("full_err", a_line_err, 0);
  endtask

  task automatic test_extra_line;
    do_reset();
    clear_mon(16'h8000);
    send_frame(9, 16'h8000);
    repeat (6) tick;
    check("extra_pixels", n_pv, 4096);
    check("extra_fdone", n_fd, 1);
    check("extra_err", a_line_err, 1);
    check("extra_y_sat", a_pix_y, 7);
  endtask

  task automatic test_vsync_abort;
    do_reset();
    clear_mon(16'h8000);
    send_frame(4, 16'h8000);
    check("abort_pre_done", n_fd, 0);
    check("abort_pre_err", a_line_err, 0);
    check("abort_pre_y", a_pix_y, 4);
    cmos_vsyn = 1'b1;
    repeat (4) tick;
    check("abort_done", n_fd, 1);
    check("abort_err", a_line_err, 1);
    check("abort_xy", {a_pix_x, a_pix_y}, 32'd0);
    clear_mon(16'h9000);
    send_frame(8, 16'h9000);
    repeat (6) tick;
    check("abort_next_pixels", n_pv, 4096);
    check("abort_next_data", n_bad, 0);
    check("abort_next_fs", n_fs, 1);
    check("abort_next_fd", n_fd, 1);
  endtask

  task automatic test_reset_midline;
    do_reset();
    vs_pulse();
    for (int i = 0; i < 100; i++) begin
      send_byte(8'h12);
      send_byte(8'h34);
    end
    rst = 1'b1;
    cmos_data = 8'h12;
    tick;
    rst = 1'b0;
    n_checks++;
    if ({a_pix_data, a_pix_valid, a_pix_x, a_pix_y, a_frame_start, a_frame_done, a_line_err} !== 52'd0) begin
      $display("FAIL midreset_outputs: got data=%h v=%b x=%0d y=%0d fs=%b fd=%b err=%b, expected all 0",
               a_pix_data, a_pix_valid, a_pix_x, a_pix_y, a_frame_start, a_frame_done, a_line_err);
    end else n_pass++;
    clear_mon(16'h0000);
    for (int i = 0; i < 50; i++) begin
      send_byte(8'h56);
      send_byte(8'h78);
    end
    end_line();
    check("midreset_quiet", n_pv, 0);
    clear_mon(16'h8000);
    send_frame(8, 16'h8000);
    repeat (6) tick;
    check("midreset_pixels", n_pv, 4096);
    check("midreset_data", n_bad, 0);
    check("midreset_fs_fd", {n_fs[7:0], n_fd[7:0]}, 16'h0101);
    check("midreset_err", a_line_err, 0);
  endtask

  task automatic test_skip;
    do_reset();
    clear_mon(16'h8000);
    send_frame(8, 16'h8000);
    check("skip_f1", n_pv2, 0);
    send_frame(8, 16'h8000);
    check("skip_f2", n_pv2, 0);
    check("skip_f2_fs", n_fs2, 0);
    send_frame(8, 16'h8000);
    repeat (6) tick;
    check("skip_f3_pixels", n_pv2, 4096);
    check("skip_f3_fs", n_fs2, 1);
    check("skip_f3_fd", n_fd2, 1);
    check("skip_err", b_line_err, 0);
    check("noskip_fd", n_fd, 3);
  endtask

  initial begin
    clear_mon(16'h0000);
    test_reset();
    test_latency();
    test_odd_line();
    test_full_frame();
    test_extra_line();
    test_vsync_abort();
    test_reset_midline();
    test_skip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
Name: cmos_capture

Overview:
- Receiver side of the 8-bit parallel CMOS camera interface (cmos_pclk / cmos_data / cmos_href / cmos_vsyn).
- Assembles byte pairs into 16-bit RGB565 pixels and tags each with x/y coordinates.
- Generates frame start/done strobes and discards a programmable number of start-up frames.
- Feeds the SDRAM write path and runs entirely in the camera pixel-clock domain.

Parameters:
- H_PIX, 512, expected pixels per line (2 bytes each).
- V_LINES, 8, expected lines per frame.
- SKIP_FRAMES, 0, complete frames discarded after reset before capture starts (0..15).
- XY_W, 16, width of pix_x / pix_y.

Ports:
- cmos_pclk  in  1  camera pixel clock; every register is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmos_data  in  8  camera byte; high byte first, then low byte.
- cmos_href  in  1  line-active qualifier; a byte is valid on each cycle where cmos_href=1.
- cmos_vsyn  in  1  frame sync; high = vertical blanking.
- pix_data  out  16  assembled pixel {first byte, second byte}.
- pix_valid  out  1  one-cycle strobe, pix_data/pix_x/pix_y valid.
- pix_x  out  XY_W  pixel column, 0..H_PIX-1.
- pix_y  out  XY_W  line index, 0..V_LINES-1.
- frame_start  out  1  one-cycle pulse at the first captured pixel of a frame.
- frame_done  out  1  one-cycle pulse after V_LINES lines have completed.
- line_err  out  1  sticky error flag, cleared by reset only.

Behaviour:
- Reset (synchronous, rst=1 on a clock edge): every output is 0, all counters are 0, byte phase = high, state = WAIT_VS. Reset wins over all other events and may be asserted mid-line or mid-frame.
- Input registers: vsyn, href and data are registered once (stage 0). vsyn is registered a second time for edge detection. vs_fall = previous vsyn 1 and current vsyn 0.
- States:
  - WAIT_VS: wait for the registered vsyn to be 1 → SYNC.
  - SYNC: on vs_fall, if skip_cnt<SKIP_FRAMES then skip_cnt++ and → SKIP; else → ACTIVE.
  - SKIP: ignore href; on vsyn=1 → SYNC.
  - ACTIVE: capture; on vsyn=1 → SYNC. This always returns to SYNC, so frames after the skip count are all captured.
- Byte assembly (ACTIVE, href_r=1):
  - phase=high: latch the byte into hi_reg; phase toggles to low.
  - phase=low: pix_data <= {hi_reg, byte}, pix_valid <= 1 on the next edge, phase toggles to high.
  - Latency: pix_valid is asserted 1 cycle after the low byte is registered, which is 2 cycles after it appears on the pins.
- Counters:
  - pix_x increments after each emitted pixel.
  - On href_r falling edge: pix_x <= 0, pix_y++, phase <= high.
  - Line check at href fall: if phase=low (odd byte count) or pix_x≠H_PIX, set line_err. The dangling byte is discarded.
  - pix_y saturates at V_LINES-1. Lines beyond V_LINES produce no pix_valid and set line_err.
- frame_start: asserted together with the first pix_valid of each captured frame (pix_x=0, pix_y=0).
- frame_done: pulses 1 cycle after the href fall that completes line V_LINES-1. Also pulses if vsyn rises mid-frame; in that case line_err is set and pix_x/pix_y/phase are cleared.
- pix_valid, frame_start and frame_done are one cycle wide. pix_x/pix_y hold their values between strobes.
- href high while vsyn high is ignored in every state.
- Arithmetic: all counters are unsigned and wrap-free (saturate). The skip counter is 4 bits.

Decomposition:
- Shared package cam_pkg: RGB565 field constants (R 15:11, G 10:5, B 4:0), state encoding typedef (WAIT_VS, SYNC, SKIP, ACTIVE), default H_PIX/V_LINES.
- One natural sub-module, cam_byte_pack: byte phase register, hi_reg and pixel strobe, driven by href_r/data_r. The top level holds the FSM, counters and error logic.

Test Plan:
- Drive one frame with the test camera generator (H_PIX=512, V_LINES=8, data starting 0x8000 and incrementing) → 4096 pix_valid pulses. Line 0 is 0x8000..0x81FF with pix_x 0..511. frame_start and frame_done each pulse exactly once. line_err=0.
- Latency: single line, bytes 0xAB then 0xCD on consecutive href cycles → pix_valid=1 with pix_data=0xABCD exactly 2 cycles after 0xCD is on the pins.
- Odd-length line: 3 bytes 0x11,0x22,0x33 then href low → one pixel 0x1122 is emitted. 0x33 is dropped. line_err=1. The next line starts at pix_x=0, first byte = high.
- SKIP_FRAMES=2: three frames → no pix_valid during frames 1–2. Frame 3 produces frame_start and full pixel output.
- vsyn rises after line 3 → frame_done pulses, line_err=1. The next frame restarts at pix_y=0 with correct data.
- rst asserted mid-line for 1 cycle → all outputs read 0 on the next edge. No pix_valid until after the next vs_fall. The first frame afterwards is captured correctly.
